// File: rtl/maze_fb_writer.sv
// Maze frame-buffer writer. Renders the static maze tile by tile into the back
// bank of the ping-pong frame RAM. It uses the reader's rotated layout,
// addr = xpos*264 + (ypos-24). The banks swap in vertical blank once the
// render has finished.
module maze_fb_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_sync,
  input  logic [7:0]  maze_color,
  output logic [9:0]  tile_addr,
  input  logic [5:0]  tile_id,
  output logic [8:0]  bmp_addr,
  input  logic [7:0]  bmp_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_bank,
  output logic        buf_sel,
  output logic        busy,
  output logic        done
);

  localparam int XMAX   = 240;
  localparam int YROWS  = 264;
  localparam int YTILE0 = 3;
  localparam int MAPW   = 30;

  typedef enum logic [2:0] {
    IDLE, MAP_REQ, MAP_WAIT, BMP_REQ, BMP_WAIT, WRITE, PEND
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  tc_q, tc_d;
  logic [5:0]  tr_q, tr_d;
  logic [2:0]  line_q, line_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  col_q, col_d;
  logic [5:0]  tid_q, tid_d;
  logic [7:0]  row_q, row_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        buf_sel_q, buf_sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  xpos_d;
  logic [8:0]  ypos_d;

  // ROM addresses are functions of the loop counters. The address (tr+3)*30+tc
  // passes 1023 on the bottom rows. The map port is only 10 bits wide, so
  // those rows wrap.
  assign tile_addr = (10'(tr_q) + 10'(YTILE0)) * 10'(MAPW) + 10'(tc_q);
  assign bmp_addr  = {tid_q, line_q};

  // Next-state, counter walk and registered write-port values.
  always_comb begin
    // NOTE: every _d gets a default first, so branches that do not touch a
    // signal hold it instead of inferring a latch.
    state_d   = state_q;
    tc_d      = tc_q;
    tr_d      = tr_q;
    line_d    = line_q;
    bit_d     = bit_q;
    col_d     = col_q;
    tid_d     = tid_q;
    row_d     = row_q;
    buf_sel_d = buf_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          col_d   = maze_color;
          tc_d    = '0;
          tr_d    = '0;
          line_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = MAP_REQ;
        end
      end
      MAP_REQ:  state_d = MAP_WAIT;
      MAP_WAIT: begin
        tid_d   = tile_id;
        state_d = BMP_REQ;
      end
      BMP_REQ:  state_d = BMP_WAIT;
      BMP_WAIT: begin
        row_d   = bmp_data;
        bit_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (line_q != 3'd7) begin
            line_d  = line_q + 3'd1;
            state_d = BMP_REQ;
          end else if (tc_q != 5'(XMAX / 8 - 1)) begin
            tc_d    = tc_q + 5'd1;
            line_d  = '0;
            state_d = MAP_REQ;
          end else if (tr_q != 6'(YROWS / 8 - 1)) begin
            tr_d    = tr_q + 6'd1;
            tc_d    = '0;
            line_d  = '0;
            state_d = MAP_REQ;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (frame_sync) begin
          buf_sel_d = ~buf_sel_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The write port is registered from the next-cycle values. It is valid
    // exactly while the state register holds WRITE.
    xpos_d    = {tc_d, line_d};
    ypos_d    = {tr_d, bit_d};
    wr_en_d   = (state_d == WRITE);
    wr_addr_d = 16'(xpos_d) * 16'(YROWS) + 16'(ypos_d);
    wr_data_d = row_d[3'd7 - bit_d] ? col_d : 8'h00;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: every register is cleared by reset, not only the FSM. A reset in
    // the middle of a render must drop wr_en on the next cycle and return the
    // front buffer to bank 0.
    if (!rst) begin
      state_q   <= IDLE;
      tc_q      <= '0;
      tr_q      <= '0;
      line_q    <= '0;
      bit_q     <= '0;
      col_q     <= '0;
      tid_q     <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      buf_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values.
      state_q   <= state_d;
      tc_q      <= tc_d;
      tr_q      <= tr_d;
      line_q    <= line_d;
      bit_q     <= bit_d;
      col_q     <= col_d;
      tid_q     <= tid_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      buf_sel_q <= buf_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign buf_sel = buf_sel_q;
  assign wr_bank = ~buf_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
